iic_byte_master: RTL and testbench
==================================

# iic_byte_master

Byte-level I2C write master that sequences the `scl_gen` SCL generator to drive the LCD2004 backpack bus. It produces START, the address byte with R/W=0, a stream of data bytes accepted through a one-entry valid/ready buffer, ACK sampling, and STOP. It sits between the LCD command sequencer (byte producer) and the open-drain SCL/SDA pads; `scl_gen` supplies bit timing.

## Interface
- `HOLD_CYCLES`, 500: `i_clk` cycles for START hold, STOP setup and bus-free time; counter width `$clog2(HOLD_CYCLES+1)`.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  pulse: begin transaction. Honoured only in IDLE.
- `i_addr`  in  7  slave address, latched on accepted `i_start`.
- `i_data`  in  8  data byte.
- `i_last`  in  1  byte is final; STOP follows its ACK.
- `i_valid`  in  1  `i_data`/`i_last` valid.
- `o_ready`  out  1  buffer can accept; transfer on `i_valid & o_ready`.
- `o_cnt_en`  out  1  to `scl_gen.i_cnt_en`.
- `i_scl_clk`  in  1  from `scl_gen.o_scl_clk`; low in first half of period.
- `i_shift_en`  in  1  from `scl_gen.o_shift_en`; pulse after SCL fall.
- `i_read_en`  in  1  from `scl_gen.o_read_en`; pulse after SCL rise.
- `i_sda`  in  1  SDA line, already synchronized.
- `o_scl_oe`  out  1  1 = pull SCL low.
- `o_sda_oe`  out  1  1 = pull SDA low.
- `o_busy`  out  1  transaction in progress.
- `o_done`  out  1  one-cycle pulse on return to IDLE.
- `o_nack`  out  1  sticky NACK flag, cleared on accepted `i_start`.

## Operation
- States: IDLE, START, BIT, ACK, WAIT, STOP_LOW, STOP_HOLD, FREE.
- SCL level: `i_scl_clk` in BIT/ACK/WAIT/STOP_LOW, else released; `o_scl_oe` = ~level.
- IDLE: `i_start` → shift reg = {i_addr,0}, SDA low, clear `o_nack`, busy=1 → START.
- START: after HOLD_CYCLES → BIT, `o_cnt_en`=1, drive shreg[7], bit count 0.
- BIT: `i_read_en` increments bit count; on `i_shift_en`: count==8 → ACK (SDA released), else shift left, drive new MSB. SDA drive: `o_sda_oe` = ~bit.
- ACK: `i_read_en` samples `i_sda` (1 = NACK, sets `o_nack`). On `i_shift_en`: NACK or current byte last → STOP_LOW (SDA low); else buffer full → pop, load, drive bit7, BIT; else → WAIT.
- WAIT: `o_cnt_en`=0 (SCL held low, clock stretched by master); buffer full → pop, load, drive bit7, `o_cnt_en`=1, BIT.
- STOP_LOW: SDA low; `i_read_en` → STOP_HOLD, `o_cnt_en`=0, SCL released.
- STOP_HOLD: after HOLD_CYCLES release SDA → FREE. FREE: after HOLD_CYCLES → IDLE, `o_done`=1, busy=0.
- Buffer: {last,data}+valid; `o_ready` = valid==0 in START/BIT/ACK/WAIT; 0 elsewhere. Buffer cleared on entry to STOP_LOW (unsent byte discarded). Address byte is never last.

## Timing
- Reset values: `o_cnt_en`=0, `o_scl_oe`=0, `o_sda_oe`=0, `o_ready`=0, `o_busy`=0, `o_done`=0, `o_nack`=0; state IDLE.
- Reset mid-transaction: bus released asynchronously; no STOP generated.
- SDA changes register one cycle after `i_shift_en`; `i_sda` sampled in the `i_read_en` cycle.
- Spurious `i_shift_en` caused by `o_cnt_en` falling in STOP_HOLD/WAIT is ignored.
- `i_start` while busy ignored; `i_valid` in IDLE not accepted.
- Push and pop never coincide: pop only when valid=1, `o_ready` requires valid=0.
- Per byte: 9 SCL periods; WAIT adds ≥1 cycle plus a fresh full period.

## Configuration
- `IIC_ACK_CHECK_EN` defined: ACK sampled as above; NACK aborts to STOP and sets `o_nack`.
- Undefined: `i_sda` ignored, `o_nack` tied 0, transaction always runs to the `i_last` byte.

## Test plan
- Reset: `i_rst_n`=0 mid-BIT → all outputs 0 same cycle, SCL/SDA released.
- `i_start`, addr 0x27, bytes 0x08 (last=0), 0x0C (last=1) pre-queued, slave ACKs → SDA bits 0x4E,0x08,0x0C MSB-first on SCL high, STOP, one `o_done`, `o_nack`=0.
- Same with 0x0C delayed 50 SCL periods → SCL held low in WAIT, no glitch, resumes with 0x0C.
- Slave NACKs address (macro on) → STOP after 9th clock, `o_nack`=1, queued 0x08 discarded, `o_done` pulses.
- Same NACK with macro off → all bytes sent, `o_nack`=0.
- `i_start` during busy and `i_valid` in IDLE → ignored, `o_ready`=0.

Source files
------------

// File: rtl/iic_byte_master.sv
// Byte-level I2C write master: START, address byte (R/W=0), buffered data bytes, ACK, STOP.
// Bit timing comes from scl_gen; define IIC_ACK_CHECK_EN to enable ACK checking / NACK abort.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus released, waiting for i_start
// START     | SDA pulled low with SCL high, START hold time
// BIT       | shifting one byte out, MSB first, one bit per SCL period
// ACK       | SDA released for the ninth SCL period, slave answers
// WAIT      | SCL stretched low while the data buffer is empty
// STOP_LOW  | SDA low, waiting for SCL to rise
// STOP_HOLD | SCL high, SDA still low for the STOP setup time
// FREE      | bus released, bus-free time before the next transaction
module iic_byte_master #(
    parameter int HOLD_CYCLES = 500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_last,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_cnt_en,
    input  logic       i_scl_clk,
    input  logic       i_shift_en,
    input  logic       i_read_en,
    input  logic       i_sda,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_BIT       = 3'd2;
    localparam logic [2:0] ST_ACK       = 3'd3;
    localparam logic [2:0] ST_WAIT      = 3'd4;
    localparam logic [2:0] ST_STOP_LOW  = 3'd5;
    localparam logic [2:0] ST_STOP_HOLD = 3'd6;
    localparam logic [2:0] ST_FREE      = 3'd7;

    logic [2:0]    state;
    logic [7:0]    shreg;
    logic [3:0]    bit_cnt;
    logic          cur_last;
    logic          buf_valid;
    logic [7:0]    buf_data;
    logic          buf_last;
    logic [TW-1:0] timer;
    logic          cnt_en;
    logic          sda_oe;
    logic          busy;
    logic          done;
    logic          nack_abort;

    logic scl_active;
    logic xfer_state;
    logic push;
    logic timer_tc;

    always_comb begin
        scl_active = (state == ST_BIT) || (state == ST_ACK) ||
                     (state == ST_WAIT) || (state == ST_STOP_LOW);
        xfer_state = (state == ST_START) || (state == ST_BIT) ||
                     (state == ST_ACK) || (state == ST_WAIT);
        push       = i_valid && xfer_state && !buf_valid;
        timer_tc   = (timer == '0);
    end

    // SCL follows scl_gen only while a byte is on the wire; otherwise it is released.
    assign o_scl_oe = scl_active && !i_scl_clk;
    assign o_ready  = xfer_state && !buf_valid;
    assign o_cnt_en = cnt_en;
    assign o_sda_oe = sda_oe;
    assign o_busy   = busy;
    assign o_done   = done;
    assign o_nack   = nack_abort;

`ifdef IIC_ACK_CHECK_EN
    logic nack_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            nack_q <= 1'b0;
        end else if (state == ST_IDLE && i_start) begin
            nack_q <= 1'b0;
        end else if (state == ST_ACK && i_read_en && i_sda) begin
            nack_q <= 1'b1;
        end
    end

    assign nack_abort = nack_q;
`else
    logic unused_sda;

    assign unused_sda = i_sda;
    assign nack_abort = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            cur_last  <= 1'b0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_last  <= 1'b0;
            timer     <= '0;
            cnt_en    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Push and pop are mutually exclusive: push needs an empty buffer, pop a full one.
            if (push) begin
                buf_valid <= 1'b1;
                buf_data  <= i_data;
                buf_last  <= i_last;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        shreg    <= {i_addr, 1'b0};
                        cur_last <= 1'b0;
                        sda_oe   <= 1'b1;
                        busy     <= 1'b1;
                        timer    <= HOLD_LOAD;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    if (timer_tc) begin
                        cnt_en  <= 1'b1;
                        sda_oe  <= ~shreg[7];
                        bit_cnt <= '0;
                        state   <= ST_BIT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_BIT: begin
                    if (i_read_en) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (i_shift_en) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= ST_ACK;
                        end else begin
                            shreg  <= {shreg[6:0], 1'b0};
                            sda_oe <= ~shreg[6];
                        end
                    end
                end

                ST_ACK: begin
                    if (i_shift_en) begin
                        if (nack_abort || cur_last) begin
                            sda_oe    <= 1'b1;
                            buf_valid <= 1'b0;
                            state     <= ST_STOP_LOW;
                        end else if (buf_valid) begin
                            shreg     <= buf_data;
                            cur_last  <= buf_last;
                            buf_valid <= 1'b0;
                            sda_oe    <= ~buf_data[7];
                            bit_cnt   <= '0;
                            state     <= ST_BIT;
                        end else begin
                            cnt_en <= 1'b0;
                            state  <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (buf_valid) begin
                        shreg     <= buf_data;
                        cur_last  <= buf_last;
                        buf_valid <= 1'b0;
                        sda_oe    <= ~buf_data[7];
                        bit_cnt   <= '0;
                        cnt_en    <= 1'b1;
                        state     <= ST_BIT;
                    end
                end

                ST_STOP_LOW: begin
                    if (i_read_en) begin
                        cnt_en <= 1'b0;
                        timer  <= HOLD_LOAD;
                        state  <= ST_STOP_HOLD;
                    end
                end

                ST_STOP_HOLD: begin
                    if (timer_tc) begin
                        sda_oe <= 1'b0;
                        timer  <= HOLD_LOAD;
                        state  <= ST_FREE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_FREE: begin
                    if (timer_tc) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_byte_master.sv
// Directed bench for iic_byte_master with a behavioural scl_gen (8-cycle SCL period)
// and an I2C slave/bus monitor that decodes bytes, ACKs, START and STOP on the wires.
module tb_iic_byte_master;

    localparam int HOLD = 20;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [6:0] i_addr  = '0;
    logic [7:0] i_data  = '0;
    logic       i_last  = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready, o_cnt_en, o_scl_oe, o_sda_oe, o_busy, o_done, o_nack;
    logic       i_sda;

    logic [2:0] gen_cnt  = '0;
    logic       scl_prev = 1'b0;
    logic       scl_clk_m, shift_en_m, read_en_m;

    logic       ack_drive = 1'b0;
    logic       scl_line, sda_line;

    int         checks = 0;
    int         errors = 0;

    int         bitpos = 0, nbytes = 0, rises = 0, starts = 0, stops = 0, dones = 0;
    logic [7:0] got [0:7];
    logic       got_ack [0:7];
    logic [7:0] sh_tb = '0;
    logic [7:0] nack_mask = '0;
    logic       busy_prev = 1'b0, scl_p = 1'b1, sda_p = 1'b1;

    iic_byte_master #(.HOLD_CYCLES(HOLD)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_last     (i_last),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_cnt_en   (o_cnt_en),
        .i_scl_clk  (scl_clk_m),
        .i_shift_en (shift_en_m),
        .i_read_en  (read_en_m),
        .i_sda      (i_sda),
        .o_scl_oe   (o_scl_oe),
        .o_sda_oe   (o_sda_oe),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_nack     (o_nack)
    );

    always #5 i_clk = ~i_clk;

    // scl_gen model: counter held at 0 while disabled, low half then high half.
    always @(posedge i_clk) begin
        if (!o_cnt_en) gen_cnt <= '0;
        else           gen_cnt <= gen_cnt + 3'd1;
        scl_prev <= scl_clk_m;
    end
    assign scl_clk_m  = gen_cnt[2];
    assign shift_en_m = scl_prev & ~scl_clk_m;
    assign read_en_m  = ~scl_prev & scl_clk_m;

    assign scl_line = ~o_scl_oe;
    assign sda_line = ~o_sda_oe & ~ack_drive;
    assign i_sda    = sda_line;

    // Slave + bus monitor, sampled on the falling clock edge.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_busy && !busy_prev) begin
                bitpos = 0; nbytes = 0; rises = 0; starts = 0; stops = 0; dones = 0;
                ack_drive = 1'b0;
            end
            if (scl_line && !scl_p) begin
                rises++;
                if (bitpos < 8) begin
                    sh_tb = {sh_tb[6:0], sda_line};
                    bitpos++;
                end else if (bitpos == 8) begin
                    if (nbytes < 8) begin
                        got[nbytes]     = sh_tb;
                        got_ack[nbytes] = sda_line;
                    end
                    nbytes++;
                    bitpos = 9;
                end
            end else if (!scl_line && scl_p) begin
                if (bitpos == 8) begin
                    ack_drive = (nbytes < 8) ? !nack_mask[nbytes] : 1'b1;
                end else if (bitpos == 9) begin
                    ack_drive = 1'b0;
                    bitpos = 0;
                end
            end
            if (scl_line && scl_p && !sda_line && sda_p) starts++;
            if (scl_line && scl_p && sda_line && !sda_p) stops++;
            if (o_done) dones++;
            busy_prev = o_busy;
            scl_p     = scl_line;
            sda_p     = sda_line;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [6:0] a);
        i_addr  = a;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l, input int dly);
        int t;
        repeat (dly) @(posedge i_clk);
        #1;
        i_valid = 1'b1; i_data = d; i_last = l;
        t = 0;
        while (!o_ready && t < 3000) begin
            @(posedge i_clk); #1;
            t++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            $display("FAIL push_timeout: data %h ready %b, required 1", d, o_ready);
            errors++;
        end else begin
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int t = 0; t < 4000; t++) begin
            @(posedge i_clk); #1;
            if (o_done) break;
        end
        checks++;
        if (o_done !== 1'b1) begin
            $display("FAIL %s_done_timeout: o_done %b, required 1", tag, o_done);
            errors++;
        end
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_ready, o_cnt_en, o_scl_oe, o_sda_oe, o_busy, o_done, o_nack} !== 7'b0) begin
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {o_ready, o_cnt_en, o_scl_oe, o_sda_oe, o_busy, o_done, o_nack});
            errors++;
        end
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic test_basic;
        nack_mask = 8'h00;
        pulse_start(7'h27);
        fork
            begin
                push_byte(8'h08, 1'b0, 0);
                push_byte(8'h0C, 1'b1, 0);
            end
            wait_done("basic");
        join
        checks++;
        if (nbytes !== 3) begin $display("FAIL basic_nbytes: got %0d, required 3", nbytes); errors++; end
        checks++;
        if (got[0] !== 8'h4E) begin $display("FAIL basic_addr: got %h, required 4e", got[0]); errors++; end
        checks++;
        if (got[1] !== 8'h08) begin $display("FAIL basic_byte1: got %h, required 08", got[1]); errors++; end
        checks++;
        if (got[2] !== 8'h0C) begin $display("FAIL basic_byte2: got %h, required 0c", got[2]); errors++; end
        checks++;
        if ({got_ack[0], got_ack[1], got_ack[2]} !== 3'b000) begin
            $display("FAIL basic_acks: got %b, required 000", {got_ack[0], got_ack[1], got_ack[2]}); errors++;
        end
        checks++;
        if (rises !== 28) begin $display("FAIL basic_scl_rises: got %0d, required 28", rises); errors++; end
        checks++;
        if (starts !== 1 || stops !== 1) begin
            $display("FAIL basic_start_stop: got %0d/%0d, required 1/1", starts, stops); errors++;
        end
        checks++;
        if (dones !== 1) begin $display("FAIL basic_done_count: got %0d, required 1", dones); errors++; end
        checks++;
        if (o_nack !== 1'b0 || o_busy !== 1'b0) begin
            $display("FAIL basic_final_flags: nack %b busy %b, required 0 0", o_nack, o_busy); errors++;
        end
    endtask

    task automatic test_wait_stretch;
        nack_mask = 8'h00;
        pulse_start(7'h27);
        fork
            begin
                push_byte(8'h08, 1'b0, 0);
                push_byte(8'h0C, 1'b1, 400);
            end
            wait_done("wait");
            begin
                repeat (300) @(posedge i_clk);
                #1;
                checks++;
                if ({o_cnt_en, o_scl_oe, o_ready, o_busy} !== 4'b0111) begin
                    $display("FAIL wait_stretch_state: cnt_en/scl_oe/ready/busy %b, required 0111",
                             {o_cnt_en, o_scl_oe, o_ready, o_busy});
                    errors++;
                end
            end
        join
        checks++;
        if (nbytes !== 3 || got[1] !== 8'h08 || got[2] !== 8'h0C) begin
            $display("FAIL wait_bytes: n %0d b1 %h b2 %h, required 3 08 0c", nbytes, got[1], got[2]); errors++;
        end
        checks++;
        if (rises !== 28) begin $display("FAIL wait_scl_rises: got %0d, required 28", rises); errors++; end
        checks++;
        if (dones !== 1) begin $display("FAIL wait_done_count: got %0d, required 1", dones); errors++; end
    endtask

    task automatic test_nack;
        nack_mask = 8'h01;
        pulse_start(7'h27);
        fork
            begin
                push_byte(8'h08, 1'b0, 0);
`ifndef IIC_ACK_CHECK_EN
                push_byte(8'h0C, 1'b1, 0);
`endif
            end
            wait_done("nack");
        join
        checks++;
        if (got_ack[0] !== 1'b1) begin $display("FAIL nack_line: got %b, required 1", got_ack[0]); errors++; end
        checks++;
        if (dones !== 1) begin $display("FAIL nack_done_count: got %0d, required 1", dones); errors++; end
`ifdef IIC_ACK_CHECK_EN
        checks++;
        if (nbytes !== 1) begin $display("FAIL nack_nbytes: got %0d, required 1", nbytes); errors++; end
        checks++;
        if (rises !== 10) begin $display("FAIL nack_scl_rises: got %0d, required 10", rises); errors++; end
        checks++;
        if (o_nack !== 1'b1) begin $display("FAIL nack_flag: got %b, required 1", o_nack); errors++; end
        checks++;
        if (stops !== 1) begin $display("FAIL nack_stop: got %0d, required 1", stops); errors++; end
`else
        checks++;
        if (nbytes !== 3 || got[2] !== 8'h0C) begin
            $display("FAIL nack_off_bytes: n %0d b2 %h, required 3 0c", nbytes, got[2]); errors++;
        end
        checks++;
        if (o_nack !== 1'b0) begin $display("FAIL nack_off_flag: got %b, required 0", o_nack); errors++; end
`endif
    endtask

    task automatic test_back_to_back;
        nack_mask = 8'h00;
        pulse_start(7'h27);
        fork
            push_byte(8'h5A, 1'b1, 0);
            wait_done("b2b");
        join
        checks++;
        if (nbytes !== 2 || got[0] !== 8'h4E || got[1] !== 8'h5A) begin
            $display("FAIL b2b_bytes: n %0d b0 %h b1 %h, required 2 4e 5a", nbytes, got[0], got[1]); errors++;
        end
        checks++;
        if (o_nack !== 1'b0) begin $display("FAIL b2b_nack_cleared: got %b, required 0", o_nack); errors++; end
        checks++;
        if (dones !== 1) begin $display("FAIL b2b_done_count: got %0d, required 1", dones); errors++; end
    endtask

    task automatic test_ignore;
        nack_mask = 8'h00;
        i_valid = 1'b1; i_data = 8'hFF; i_last = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b0) begin
            $display("FAIL idle_valid: ready %b busy %b, required 0 0", o_ready, o_busy); errors++;
        end
        i_valid = 1'b0;
        pulse_start(7'h27);
        fork
            begin
                repeat (60) @(posedge i_clk);
                #1;
                pulse_start(7'h11);
            end
            push_byte(8'h0C, 1'b1, 0);
            wait_done("ignore");
        join
        checks++;
        if (nbytes !== 2 || got[0] !== 8'h4E || got[1] !== 8'h0C) begin
            $display("FAIL ignore_bytes: n %0d b0 %h b1 %h, required 2 4e 0c", nbytes, got[0], got[1]); errors++;
        end
        checks++;
        if (starts !== 1 || dones !== 1) begin
            $display("FAIL ignore_start_done: got %0d/%0d, required 1/1", starts, dones); errors++;
        end
    endtask

    task automatic test_reset_mid_bit;
        nack_mask = 8'h00;
        pulse_start(7'h27);
        repeat (60) @(posedge i_clk);
        #1;
        checks++;
        if ({o_busy, o_cnt_en, o_ready} !== 3'b111) begin
            $display("FAIL midbit_precondition: busy/cnt_en/ready %b, required 111", {o_busy, o_cnt_en, o_ready});
            errors++;
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_cnt_en, o_scl_oe, o_sda_oe, o_busy, o_done, o_nack} !== 7'b0) begin
            $display("FAIL midbit_reset_outputs: got %b, required 0000000",
                     {o_ready, o_cnt_en, o_scl_oe, o_sda_oe, o_busy, o_done, o_nack});
            errors++;
        end
        checks++;
        if ({scl_line, sda_line} !== 2'b11) begin
            $display("FAIL midbit_bus_released: scl/sda %b, required 11", {scl_line, sda_line}); errors++;
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_stretch();
        test_nack();
        test_back_to_back();
        test_ignore();
        test_reset_mid_bit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
